branch_seq_ctrl: RTL

//  Multi-cycle branch resolution controller for RV32I B-type instructions.

---
 rtl/branch_seq_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/branch_seq_ctrl.sv
// Purpose: multi-cycle RV32I branch resolver; slice-serial MSB-first compare, returns taken + next PC.
// Latency: 1..NSL compare cycles after accept (equal operands take NSL), illegal funct3 responds next cycle.
// Backpressure: valid/ready on both sides; result held in DONE until resp_ready, flush drops it.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid / req_ready   request handshake (ready only while idle)
//   funct3                  B-type condition select
//   rs1_data, rs2_data      operands compared slice by slice
//   pc, imm                 branch PC and sign-extended byte offset
//   flush                   pipeline redirect, aborts any in-flight work
//   resp_valid / resp_ready response handshake
//   taken, next_pc, illegal result fields, stable while resp_valid & !resp_ready
//   busy                    controller not idle
module branch_seq_ctrl #(
    parameter int XLEN  = 32,
    parameter int SLICE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            taken,
    output logic [XLEN-1:0] next_pc,
    output logic            illegal,
    output logic            busy
);

    localparam int NSL = XLEN / SLICE;
    localparam int KW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [KW-1:0] TOP_IDX = KW'(NSL - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT           state;
    stateT           nextState;

    logic [XLEN-1:0] opA;
    logic [XLEN-1:0] opB;
    logic [XLEN-1:0] pcReg;
    logic [XLEN-1:0] immReg;
    logic [2:0]      f3Reg;
    logic [KW-1:0]   sliceIdx;

    logic            takenReg;
    logic [XLEN-1:0] nextPcReg;
    logic            illegalReg;

    logic [SLICE-1:0] slicesA [NSL];
    logic [SLICE-1:0] slicesB [NSL];
    logic [SLICE-1:0] sliceA;
    logic [SLICE-1:0] sliceB;
    logic             sliceDiff;
    logic             cmpEq;
    logic             cmpLt;
    logic             decision;
    logic [XLEN-1:0]  target;
    logic             cmpDone;
    logic             accept;
    logic             illegalIn;

    // funct3 010/011 are not branch encodings.
    assign illegalIn = (funct3[2:1] == 2'b01);
    // A flush in IDLE blocks the accept even though req_ready is high.
    assign accept    = req_valid && (state == IDLE) && !flush;

    // Current slice of each operand. For signed compares the top slice has
    // its sign bit flipped, which turns two's complement order into plain
    // unsigned order for that slice; lower slices are unsigned either way.
    always_comb begin
        for (int s = 0; s < NSL; s++) begin
            slicesA[s] = opA[s*SLICE +: SLICE];
            slicesB[s] = opB[s*SLICE +: SLICE];
        end
        sliceA = slicesA[sliceIdx];
        sliceB = slicesB[sliceIdx];
        if ((f3Reg[2:1] == 2'b10) && (sliceIdx == TOP_IDX)) begin
            sliceA[SLICE-1] = ~sliceA[SLICE-1];
            sliceB[SLICE-1] = ~sliceB[SLICE-1];
        end
    end

    assign sliceDiff = (sliceA != sliceB);

    // eq/lt only mean anything on the cycle the compare terminates.
    always_comb begin
        cmpEq = 1'b0;
        cmpLt = 1'b0;
        if (sliceDiff) begin
            cmpLt = (sliceA < sliceB);
        end else begin
            cmpEq = 1'b1;
        end
    end

    // funct3[2] picks lt vs eq, funct3[0] inverts (BNE, BGE, BGEU).
    assign decision = (f3Reg[2] ? cmpLt : cmpEq) ^ f3Reg[0];
    assign target   = decision ? (pcReg + immReg) : (pcReg + XLEN'(4));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        cmpDone   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    nextState = illegalIn ? DONE : CMP;
                end
            end
            CMP: begin
                if (sliceDiff || (sliceIdx == '0)) begin
                    nextState = DONE;
                    cmpDone   = 1'b1;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
        // Redirect wins over everything, including a same-cycle resp_ready.
        if (flush) begin
            nextState = IDLE;
            cmpDone   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opA        <= '0;
            opB        <= '0;
            pcReg      <= '0;
            immReg     <= '0;
            f3Reg      <= '0;
            sliceIdx   <= '0;
            takenReg   <= 1'b0;
            nextPcReg  <= '0;
            illegalReg <= 1'b0;
        end else if (accept) begin
            opA      <= rs1_data;
            opB      <= rs2_data;
            pcReg    <= pc;
            immReg   <= imm;
            f3Reg    <= funct3;
            sliceIdx <= TOP_IDX;
            if (illegalIn) begin
                // Goes straight to DONE, so the result is set up here.
                takenReg   <= 1'b0;
                nextPcReg  <= pc + XLEN'(4);
                illegalReg <= 1'b1;
            end
        end else if (state == CMP && !flush) begin
            if (cmpDone) begin
                takenReg   <= decision;
                nextPcReg  <= target;
                illegalReg <= 1'b0;
            end else begin
                sliceIdx <= sliceIdx - KW'(1);
            end
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == DONE);
    assign busy       = (state != IDLE);
    assign taken      = takenReg;
    assign next_pc    = nextPcReg;
    assign illegal    = illegalReg;

endmodule
